// File: rtl/corr_accum_64_pkg.sv
// Shared correlator definitions: parameter defaults and the controller state encoding.
package corr_pkg;

  localparam int N_LAG_DEF = 64;
  localparam int DW_DEF    = 8;
  localparam int AW_DEF    = 32;

  typedef enum logic [1:0] {
    S_CLR  = 2'd0,
    S_IDLE = 2'd1,
    S_ACC  = 2'd2
  } state_e;

endpackage

// File: rtl/corr_accum_64_if.sv
// Host/upstream bundle of the lag correlator; master drives stimulus, slave is the accumulator.
interface corr_accum_64_if
  import corr_pkg::*;
#(
  parameter int N_LAG = N_LAG_DEF,
  parameter int DW    = DW_DEF,
  parameter int AW    = AW_DEF
);
  localparam int LW = $clog2(N_LAG);

  // shift_valid qualifies shift for one cycle and has no backpressure; rd_req is held by the
  // host until the one-cycle rd_valid pulse, and rd_data is only meaningful while rd_valid is high.
  logic          clr;
  logic          burst_start;
  logic [DW-1:0] sample;
  logic [DW-1:0] shift;
  logic          shift_valid;
  logic          rd_req;
  logic [LW-1:0] rd_addr;
  logic [AW-1:0] rd_data;
  logic          rd_valid;
  logic [31:0]   burst_cnt;
  logic          busy;
  logic          ovf;
  state_e        dbg_state;

  modport master (
    output clr, burst_start, sample, shift, shift_valid, rd_req, rd_addr,
    input  rd_data, rd_valid, burst_cnt, busy, ovf, dbg_state
  );

  modport slave (
    input  clr, burst_start, sample, shift, shift_valid, rd_req, rd_addr,
    output rd_data, rd_valid, burst_cnt, busy, ovf, dbg_state
  );

endinterface

// File: rtl/corr_accum_64_bin_ram.sv
// Simple dual-port bin memory: one write port, one registered read port, read-first on collision.
module corr_bin_ram #(
  parameter int DEPTH = 64,
  parameter int W     = 32
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [W-1:0]             wdata_i,
  input  logic                     re_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [W-1:0]             rdata_o
);

  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/corr_accum_64.sv
// Lag-correlation accumulator: bin[lag] += sample*shift through a 3-stage read-modify-write
// pipeline with saturation, a zeroing sweep after reset/clear, and a low-priority host read port.
module corr_accum_64
  import corr_pkg::*;
#(
  parameter int N_LAG = N_LAG_DEF,
  parameter int DW    = DW_DEF,
  parameter int AW    = AW_DEF
) (
  input  logic           clk,
  input  logic           rst,
  corr_accum_64_if.slave bus
);

  localparam int LW = $clog2(N_LAG);
  localparam int PW = 2 * DW;

  state_e        state_q;
  logic          busy_q;
  logic [LW-1:0] clr_addr_q;
  logic [LW-1:0] lag_q;
  logic [31:0]   burst_cnt_q;
  logic          ovf_q;

  // p_*: product stage waiting for RAM data; w_*: sum being written; l_*: sum written last cycle
  logic          p_v_q, w_v_q, l_v_q;
  logic [LW-1:0] p_a_q, w_a_q, l_a_q;
  logic [PW-1:0] p_prod_q;
  logic [AW-1:0] w_d_q, l_d_q;

  logic          rd_valid_q;
  logic [AW-1:0] rd_hold_q;

  logic          acc;
  logic          host_rd;
  logic          ram_we, ram_re;
  logic [LW-1:0] ram_waddr, ram_raddr;
  logic [AW-1:0] ram_wdata, ram_rdata;
  logic [AW-1:0] base;
  logic [AW:0]   sum_w;
  logic [AW-1:0] sum_sat;
  logic          sat;

  assign acc     = (state_q == S_ACC) && bus.shift_valid && !bus.burst_start && !bus.clr;
  assign host_rd = bus.rd_req && !rd_valid_q && !acc && !bus.clr && (state_q != S_CLR);

  always_comb begin
    ram_we    = w_v_q;
    ram_waddr = w_a_q;
    ram_wdata = w_d_q;
    if (state_q == S_CLR) begin
      ram_we    = 1'b1;
      ram_waddr = clr_addr_q;
      ram_wdata = '0;
    end
    ram_re    = acc || host_rd;
    ram_raddr = acc ? lag_q : bus.rd_addr;
  end

  corr_bin_ram #(
    .DEPTH (N_LAG),
    .W     (AW)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (ram_wdata),
    .re_i    (ram_re),
    .raddr_i (ram_raddr),
    .rdata_o (ram_rdata)
  );

  // The RAM read missed the write landing in the same edge and the one still queued; the younger wins.
  always_comb begin
    base = ram_rdata;
    if (l_v_q && (l_a_q == p_a_q)) base = l_d_q;
    if (w_v_q && (w_a_q == p_a_q)) base = w_d_q;
    sum_w   = {1'b0, base} + {{(AW + 1 - PW){1'b0}}, p_prod_q};
    sat     = sum_w[AW];
    sum_sat = sat ? '1 : sum_w[AW-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst || bus.clr) begin
      state_q     <= S_CLR;
      busy_q      <= 1'b1;
      clr_addr_q  <= '0;
      lag_q       <= '0;
      burst_cnt_q <= '0;
      ovf_q       <= 1'b0;
    end else begin
      case (state_q)
        S_CLR: begin
          if (clr_addr_q == LW'(N_LAG - 1)) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            clr_addr_q <= clr_addr_q + LW'(1);
          end
        end
        S_IDLE: begin
          if (bus.burst_start) begin
            state_q <= S_ACC;
            lag_q   <= '0;
          end
        end
        S_ACC: begin
          if (bus.burst_start) begin
            lag_q <= '0;
          end else if (bus.shift_valid) begin
            lag_q <= lag_q + LW'(1);
            if (lag_q == LW'(N_LAG - 1)) begin
              state_q     <= S_IDLE;
              burst_cnt_q <= burst_cnt_q + 32'd1;
            end
          end
        end
        default: begin
          state_q    <= S_CLR;
          busy_q     <= 1'b1;
          clr_addr_q <= '0;
        end
      endcase
      if (p_v_q && sat) ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || bus.clr) begin
      p_v_q <= 1'b0;
      w_v_q <= 1'b0;
      l_v_q <= 1'b0;
    end else begin
      p_v_q <= acc;
      w_v_q <= p_v_q;
      l_v_q <= w_v_q;
    end
    p_a_q    <= lag_q;
    p_prod_q <= PW'(bus.sample) * PW'(bus.shift);
    w_a_q    <= p_a_q;
    w_d_q    <= sum_sat;
    l_a_q    <= w_a_q;
    l_d_q    <= w_d_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_q <= 1'b0;
      rd_hold_q  <= '0;
    end else begin
      rd_valid_q <= host_rd;
      if (rd_valid_q) rd_hold_q <= ram_rdata;
    end
  end

  assign bus.rd_data   = rd_valid_q ? ram_rdata : rd_hold_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.burst_cnt = burst_cnt_q;
  assign bus.busy      = busy_q;
  assign bus.ovf       = ovf_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_corr_accum_64.sv
// Directed bench for corr_accum_64: host reads are scoreboarded against hand-computed bin values.
module tb_corr_accum_64;
  import corr_pkg::*;

  localparam int N_LAG = 64;
  localparam int DW    = 8;
  localparam int AW    = 32;
  localparam int LW    = $clog2(N_LAG);

  logic clk = 1'b0;
  logic rst;

  corr_accum_64_if #(.N_LAG(N_LAG), .DW(DW), .AW(AW)) bus_if ();

  corr_accum_64 #(.N_LAG(N_LAG), .DW(DW), .AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  logic [AW-1:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;
  bit mon_en   = 1'b0;
  bit in_burst = 1'b0;
  int early_rd = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Read-data monitor
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en && bus_if.rd_valid === 1'b1) begin
        if (in_burst) early_rd++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL rd_unexpected: got rd_data 0x%0h, expected no read response", bus_if.rd_data);
        end else begin
          check("rd_data", bus_if.rd_data, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at time limit, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic read_bin(input int addr, input logic [AW-1:0] exp);
    int waited = 0;
    exp_q.push_back(exp);
    bus_if.rd_addr = LW'(addr);
    bus_if.rd_req  = 1'b1;
    do begin
      @(negedge clk);
      waited++;
    end while (bus_if.rd_valid !== 1'b1 && waited < 300);
    if (bus_if.rd_valid !== 1'b1) begin
      n_checks++;
      n_errors++;
      $display("FAIL rd_timeout: got no rd_valid for bin %0d, expected a response", addr);
      void'(exp_q.pop_back());
    end
    tick(1);
    bus_if.rd_req = 1'b0;
  endtask

  // shc == 0 selects shift = lag+1, otherwise shift is held at shc
  task automatic burst(input int smp, input int shc, input int nvalid, input bit gap);
    in_burst = 1'b1;
    bus_if.burst_start = 1'b1;
    tick(1);
    bus_if.burst_start = 1'b0;
    for (int i = 0; i < nvalid; i++) begin
      bus_if.sample      = DW'(smp);
      bus_if.shift       = (shc == 0) ? DW'(i + 1) : DW'(shc);
      bus_if.shift_valid = 1'b1;
      tick(1);
      if (gap) begin
        bus_if.shift_valid = 1'b0;
        tick(1);
      end
    end
    bus_if.shift_valid = 1'b0;
    in_burst = 1'b0;
  endtask

  task automatic do_clr();
    int waited = 0;
    bus_if.clr = 1'b1;
    tick(1);
    bus_if.clr = 1'b0;
    do begin
      @(negedge clk);
      waited++;
    end while (bus_if.busy !== 1'b0 && waited < 200);
    check("clr_sweep_done", {31'b0, bus_if.busy}, 32'd0);
    tick(1);
  endtask

  task automatic preload(input logic [AW-1:0] val);
    for (int k = 0; k < N_LAG; k++) dut.u_ram.mem_q[k] <= val;
    tick(1);
  endtask

  initial begin
    int busy_cycles;
    int waited;
    rst                = 1'b1;
    bus_if.clr         = 1'b0;
    bus_if.burst_start = 1'b0;
    bus_if.sample      = '0;
    bus_if.shift       = '0;
    bus_if.shift_valid = 1'b0;
    bus_if.rd_req      = 1'b0;
    bus_if.rd_addr     = '0;
    repeat (3) @(posedge clk);
    #1;
    rst    = 1'b0;
    mon_en = 1'b1;

    // Reset sweep: 64 busy cycles, then idle with empty bins
    busy_cycles = 0;
    waited      = 0;
    while (waited < 200) begin
      @(negedge clk);
      waited++;
      if (bus_if.busy === 1'b1) busy_cycles++;
      else break;
    end
    check("reset_busy_cycles", 32'(busy_cycles), 32'd64);
    check("reset_state_idle", 32'(bus_if.dbg_state), 32'(S_IDLE));
    check("reset_burst_cnt", bus_if.burst_cnt, 32'd0);
    check("reset_ovf", {31'b0, bus_if.ovf}, 32'd0);
    tick(1);
    read_bin(0, 0);
    read_bin(31, 0);
    read_bin(63, 0);

    // Back-to-back burst: bin[k] = 3*(k+1)
    burst(3, 0, 64, 1'b0);
    tick(4);
    check("single_burst_cnt", bus_if.burst_cnt, 32'd1);
    read_bin(0, 3);
    read_bin(1, 6);
    read_bin(31, 96);
    read_bin(63, 192);

    // Two gapped bursts: bin[k] = 6*(k+1)
    do_clr();
    check("clr_burst_cnt", bus_if.burst_cnt, 32'd0);
    burst(3, 0, 64, 1'b1);
    burst(3, 0, 64, 1'b1);
    tick(4);
    check("gapped_burst_cnt", bus_if.burst_cnt, 32'd2);
    read_bin(0, 6);
    read_bin(10, 66);
    read_bin(63, 384);

    // Truncated after 10 valids, then full burst
    do_clr();
    burst(3, 0, 10, 1'b0);
    burst(3, 0, 64, 1'b0);
    tick(4);
    check("trunc_burst_cnt", bus_if.burst_cnt, 32'd1);
    read_bin(0, 6);
    read_bin(9, 60);
    read_bin(10, 33);
    read_bin(63, 192);

    // Truncated after 1 valid: bin 0 is re-read while its first update is still being written
    do_clr();
    burst(5, 0, 1, 1'b0);
    burst(5, 0, 64, 1'b0);
    tick(4);
    read_bin(0, 10);
    read_bin(1, 10);
    read_bin(2, 15);

    // Exact fill to all-ones does not flag overflow
    do_clr();
    preload(32'hFFFF_FFFF - 32'd65025);
    burst(255, 255, 64, 1'b0);
    tick(4);
    check("exact_fill_ovf", {31'b0, bus_if.ovf}, 32'd0);
    read_bin(0, 32'hFFFF_FFFF);
    read_bin(63, 32'hFFFF_FFFF);

    // Near-full bins saturate and set the sticky overflow
    do_clr();
    preload(32'hFFFF_FFFF - 32'd99);
    burst(255, 255, 64, 1'b0);
    tick(4);
    check("sat_ovf", {31'b0, bus_if.ovf}, 32'd1);
    check("sat_burst_cnt", bus_if.burst_cnt, 32'd1);
    read_bin(0, 32'hFFFF_FFFF);
    read_bin(40, 32'hFFFF_FFFF);

    // Clear mid-burst discards everything
    burst(255, 255, 20, 1'b0);
    do_clr();
    check("midclr_ovf", {31'b0, bus_if.ovf}, 32'd0);
    check("midclr_burst_cnt", bus_if.burst_cnt, 32'd0);
    read_bin(0, 0);
    read_bin(19, 0);
    read_bin(63, 0);

    // Host read held through a back-to-back burst waits for the burst to end
    fork
      burst(2, 0, 64, 1'b0);
      begin
        tick(3);
        read_bin(5, 12);
      end
    join
    tick(4);
    check("held_rd_not_early", 32'(early_rd), 32'd0);
    check("held_rd_burst_cnt", bus_if.burst_cnt, 32'd1);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/corr_accum_64.md
CORR_ACCUM_64 -- requirements
Module: corr_accum_64

Interface
REQ-001 SHALL have parameter N_LAG, default 64, number of lag bins, power of two.
REQ-002 SHALL have parameter DW, default 8, input sample width.
REQ-003 SHALL have parameter AW, default 32, accumulator bin width.
REQ-004 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port clr  input  1  one-cycle pulse; zero all bins and burst_cnt.
REQ-007 SHALL have port burst_start  input  1  pulse; starts a new lag burst, lag index set to 0.
REQ-008 SHALL have port sample  input  DW  current sample (upstream delayed data out), unsigned, stable during a burst.
REQ-009 SHALL have port shift  input  DW  delayed sample for the current lag (upstream shift data), unsigned.
REQ-010 SHALL have port shift_valid  input  1  shift holds the value for the current lag this cycle.
REQ-011 SHALL have port rd_req  input  1  host read request, held until rd_valid.
REQ-012 SHALL have port rd_addr  input  log2(N_LAG)  bin to read.
REQ-013 SHALL have port rd_data  output  AW  bin value, valid when rd_valid.
REQ-014 SHALL have port rd_valid  output  1  one-cycle pulse; read serviced.
REQ-015 SHALL have port burst_cnt  output  32  count of completed bursts since the last clear.
REQ-016 SHALL have port busy  output  1  high during the clear sweep.
REQ-017 SHALL have port ovf  output  1  sticky; some bin saturated since the last clear.

Function
REQ-018 SHALL implement FSM S_CLR, S_IDLE, S_ACC; S_CLR→S_IDLE after writing bin N_LAG-1; S_IDLE→S_ACC on burst_start; S_ACC→S_IDLE after the N_LAG-th shift_valid.
REQ-019 SHALL, in S_CLR, write zero to one bin per cycle, addr 0..N_LAG-1; busy=1; burst_start, shift_valid and rd_req ignored.
REQ-020 SHALL, in S_ACC, on each shift_valid: product = sample*shift (2*DW bits, unsigned); bin[lag] += product; lag increments by 1.
REQ-021 SHALL pipeline read-modify-write in 3 stages: cycle 0 RAM read plus product register; cycle 1 add; cycle 2 write; bin update visible to rd 3 cycles after shift_valid.
REQ-022 SHALL forward the in-flight write value when a stage-0 read address matches a pending write address.
REQ-023 SHALL saturate a bin at 2^AW-1 when the sum exceeds it, and set ovf.
REQ-024 SHALL increment burst_cnt when lag N_LAG-1 is accepted; burst_cnt wraps at 2^32.
REQ-025 SHALL, on burst_start in S_ACC (truncated burst), restart with lag=0; partial products already issued complete; burst_cnt not incremented.
REQ-026 SHALL ignore shift_valid in S_IDLE.
REQ-027 SHALL service rd_req only in a cycle with no stage-0 accumulate read; rd_valid and rd_data 1 cycle after the RAM read; host reads have the lowest priority.
REQ-028 SHALL, on clr in any state, abort the burst, discard the pipeline, enter S_CLR, and clear burst_cnt and ovf; clr during S_CLR restarts the sweep at addr 0.
REQ-029 SHALL give burst_start and clr in the same cycle to clr.

Reset
REQ-030 SHALL, on rst: enter S_CLR at addr 0, lag=0, burst_cnt=0, ovf=0, rd_valid=0, rd_data=0, pipeline valid bits=0; busy=1 the next cycle.
REQ-031 SHALL not require an initial block for RAM contents; the reset sweep zeros all bins.

Structure
REQ-032 SHALL place N_LAG, DW, AW defaults and the FSM state encoding in the shared correlator package corr_pkg.
REQ-033 SHALL contain one sub-module, corr_bin_ram: simple dual-port RAM, N_LAG x AW, 1-cycle registered read, block-RAM style.

Verification
REQ-034 SHALL cover: rst then wait 64 cycles → busy falls on cycle 65; all bins read 0; burst_cnt=0.
REQ-035 SHALL cover: sample=3, shift=lag+1 for 64 valids, back-to-back → bin[k]=3*(k+1); burst_cnt=1.
REQ-036 SHALL cover: same burst twice with shift_valid gapped every other cycle → bin[k]=6*(k+1); burst_cnt=2.
REQ-037 SHALL cover: bins preloaded near full (2^32-100), sample=255, shift=255 → bin=0xFFFFFFFF; ovf=1.
REQ-038 SHALL cover: burst_start after 10 valids, then a full burst → bins 0..9 get two products, bins 10..63 one; burst_cnt=1.
REQ-039 SHALL cover: rd_req held during a full burst → rd_valid only after the burst ends; clr mid-burst → all bins 0, ovf=0.
